// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - word-wide data memory that answers load/store requests after LATENCY wait states
module dmem_wait_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic         cap_we;
  logic [31:0]  cap_addr;
  logic [31:0]  cap_wdata;
  logic [3:0]   cap_be;
  logic [31:0]  mem [DEPTH];

  logic              in_idle;
  logic              c_we;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic [3:0]        c_be;
  logic              c_err;
  logic [ADDR_W-1:0] c_idx;
  logic              commit;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // With zero latency the commit happens on the acceptance edge, so the live
  // request is used instead of the captured copy.
  always_comb begin
    in_idle = (state == IDLE);
    c_we    = in_idle ? req_we    : cap_we;
    c_addr  = in_idle ? req_addr  : cap_addr;
    c_wdata = in_idle ? req_wdata : cap_wdata;
    c_be    = in_idle ? req_be    : cap_be;
    c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:ADDR_W+2] != '0);
    c_idx   = c_addr[ADDR_W+1:2];
    commit  = ((state == WAIT) && (cnt == 4'd0)) ||
              (in_idle && req_valid && (LATENCY == 0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= c_err;
        rsp_rdata <= (!c_err && !c_we) ? mem[c_idx] : 32'd0;
        if (!c_err && c_we) begin
          for (int b = 0; b < 4; b++)
            if (c_be[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - randomized bench with a per-cycle reference model for two latency builds
module tb_dmem_wait_responder;
  localparam int DEPTH = 256;
  localparam int LAT0  = 2;
  localparam int LAT1  = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  always #5 clk = ~clk;

  dmem_wait_responder #(.DEPTH(DEPTH), .ADDR_W(8), .LATENCY(LAT0)) u0 (
    .clock(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]));

  dmem_wait_responder #(.DEPTH(DEPTH), .ADDR_W(8), .LATENCY(LAT1)) u1 (
    .clock(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: one outstanding transaction per instance, its response
  // due a fixed number of edges after acceptance.
  logic        pend  [2];
  int          due   [2];
  logic [31:0] e_rd  [2];
  logic        e_err [2];
  logic [31:0] mem_m [2][DEPTH];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        pend[k] = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[k][i] = 32'd0;
      end else if (pend[k]) begin
        if (cyc >= due[k] && rsp_ready[k]) pend[k] = 1'b0;
      end else if (req_valid[k]) begin
        pend[k]  = 1'b1;
        due[k]   = cyc + 1 + lat_of(k);
        e_err[k] = (req_addr[k] % 4 != 0) || (req_addr[k] >= DEPTH * 4);
        e_rd[k]  = 32'd0;
        if (!e_err[k] && !req_we[k]) e_rd[k] = mem_m[k][req_addr[k] / 4];
        if (!e_err[k] && req_we[k])
          for (int b = 0; b < 4; b++)
            if (req_be[k][b]) mem_m[k][req_addr[k] / 4][8*b +: 8] = req_wdata[k][8*b +: 8];
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < 2; k++) begin
        logic ev;
        ev = pend[k] && (cyc >= due[k]);
        chk($sformatf("u%0d req_ready", k), 32'(req_ready[k]), 32'(!pend[k]));
        chk($sformatf("u%0d busy", k), 32'(busy[k]), 32'(pend[k]));
        chk($sformatf("u%0d rsp_valid", k), 32'(rsp_valid[k]), 32'(ev));
        chk($sformatf("u%0d rsp_rdata", k), rsp_rdata[k], ev ? e_rd[k] : 32'd0);
        chk($sformatf("u%0d rsp_err", k), 32'(rsp_err[k]), ev ? 32'(e_err[k]) : 32'd0);
      end
    end
  end

  task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic early, input int delay, input logic hold_req,
                     output logic [31:0] rd, output logic err, output int lat, output int acc, output int hs);
    int n;
    req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata; req_be[k] = be;
    req_valid[k] = 1'b1;
    rsp_ready[k] = early;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[k] && n < 50);
    if (n >= 50) chk("accept timeout", 32'(n), 32'd0);
    @(posedge clk); #1 acc = cyc;
    #1 req_valid[k] = hold_req;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid[k] && lat < 50);
    if (lat >= 50) chk("response timeout", 32'(lat), 32'd0);
    rd = rsp_rdata[k];
    err = rsp_err[k];
    if (delay > 0) begin
      rsp_ready[k] = 1'b0;
      repeat (delay) begin
        @(negedge clk);
        chk("hold rdata stable", rsp_rdata[k], rd);
        chk("hold valid stable", 32'(rsp_valid[k]), 32'd1);
        chk("hold req_ready low", 32'(req_ready[k]), 32'd0);
      end
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1 hs = cyc;
    #1 rsp_ready[k] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat, acc, hs, prev_acc;

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 0; req_we[k] = 0; req_addr[k] = 0; req_wdata[k] = 0;
      req_be[k] = 0; rsp_ready[k] = 0;
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready[0]), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset busy", 32'(busy[0]), 32'd0);
    @(posedge clk); #2;

    txn(0, 1, 32'h0, 32'h5, 4'hF, 0, 0, 0, rd, err, lat, acc, hs);
    chk("store latency", 32'(lat), 32'd3);
    chk("store err", 32'(err), 32'd0);
    txn(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, rd, err, lat, acc, hs);
    chk("load after store", rd, 32'h5);

    txn(0, 1, 32'h8, 32'hAABBCCDD, 4'hF, 0, 1, 0, rd, err, lat, acc, hs);
    txn(0, 1, 32'h8, 32'h11223344, 4'h5, 1, 0, 0, rd, err, lat, acc, hs);
    txn(0, 0, 32'h8, 32'h0, 4'h0, 0, 0, 0, rd, err, lat, acc, hs);
    chk("byte-lane merge", rd, 32'hAA22CC44);

    txn(0, 0, 32'h2, 32'h0, 4'h0, 0, 0, 0, rd, err, lat, acc, hs);
    chk("misaligned err", 32'(err), 32'd1);
    chk("misaligned rdata", rd, 32'd0);
    txn(0, 0, 32'h400, 32'h0, 4'h0, 0, 0, 0, rd, err, lat, acc, hs);
    chk("out of range err", 32'(err), 32'd1);
    txn(0, 1, 32'h401, 32'hFFFFFFFF, 4'hF, 0, 0, 0, rd, err, lat, acc, hs);
    txn(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, rd, err, lat, acc, hs);
    chk("memory unchanged", rd, 32'h5);

    txn(0, 0, 32'h8, 32'h0, 4'h0, 0, 5, 1, rd, err, lat, acc, hs);
    chk("held rdata", rd, 32'hAA22CC44);
    txn(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, rd, err, lat, acc, prev_acc);
    chk("accept after handshake", 32'(acc), 32'(hs + 1));
    chk("second load data", rd, 32'h5);

    req_we[0] = 1; req_addr[0] = 32'h4; req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
    req_valid[0] = 1;
    @(posedge clk); #2 req_valid[0] = 0;
    @(negedge clk);
    chk("busy in wait", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("abort req_ready", 32'(req_ready[0]), 32'd1);
    chk("abort rsp_valid", 32'(rsp_valid[0]), 32'd0);
    @(posedge clk); #2;
    txn(0, 0, 32'h4, 32'h0, 4'h0, 0, 0, 0, rd, err, lat, acc, hs);
    chk("aborted store not written", rd, 32'd0);

    txn(1, 1, 32'h10, 32'hCAFEF00D, 4'hF, 1, 0, 0, rd, err, lat, acc, hs);
    chk("lat0 latency", 32'(lat), 32'd1);
    prev_acc = acc;
    for (int i = 0; i < 4; i++) begin
      txn(1, 0, 32'h10, 32'h0, 4'h0, 1, 0, 0, rd, err, lat, acc, hs);
      chk("lat0 period", 32'(acc - prev_acc), 32'd2);
      chk("lat0 data", rd, 32'hCAFEF00D);
      prev_acc = acc;
    end

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 60; i++) begin
        int mode;
        logic [31:0] a;
        logic e;
        mode = $urandom_range(0, 9);
        if (mode < 8)       a = 32'($urandom_range(0, 15)) << 2;
        else if (mode == 8) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        else                a = $urandom;
        e = 1'($urandom_range(0, 1));
        txn(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), e,
            e ? 0 : $urandom_range(0, 3), 0, rd, err, lat, acc, hs);
        chk("random latency", 32'(lat), 32'(lat_of(k) + 1));
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
- Data-memory responder: the memory end of the processor's load/store port.
- Accepts word-sized load/store requests over a valid/ready handshake, models a configurable number of wait states, and returns a response (read data or store acknowledge) over a second valid/ready handshake.
- Replaces the zero-latency data memory so the core's load/store path can be exercised against a stalling memory.

Parameters:
- DEPTH, 256: number of 32-bit words; power of two, minimum 4.
- ADDR_W, 8: word-index width, equal to log2(DEPTH).
- LATENCY, 2: wait cycles between request acceptance and response; range 0..15.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables; bit i enables byte lane i (bits 8i+7:8i).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE and the wait counter clears.
  - req_ready = 1 in the first cycle after reset.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - All memory words clear to 0 (reset loop over DEPTH).
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state == IDLE), combinational.
  - busy = (state != IDLE).
- IDLE:
  - On req_valid && req_ready, capture we/addr/wdata/be.
  - Next state is WAIT with counter = LATENCY-1 if LATENCY > 0.
  - Next state is RESP if LATENCY == 0.
- WAIT:
  - Counter decrements each cycle.
  - At 0, move to RESP.
  - req_valid is ignored and not accepted.
- Response timing: the entry edge into RESP is the commit edge. rsp_valid rises LATENCY+1 cycles after the acceptance edge.
- Commit edge, error check:
  - err = (addr[1:0] != 0) OR (addr[31:ADDR_W+2] != 0).
  - The word index is addr[ADDR_W+1:2].
- Commit edge, store with no error: write only the byte lanes whose req_be bit is set; other bytes keep their value. rsp_rdata = 0.
- Commit edge, load with no error: rsp_rdata = the memory word at the index.
- Commit edge, error: no memory write; rsp_rdata = 0; rsp_err = 1.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid/rsp_rdata/rsp_err on that edge.
  - req_ready returns to 1 the cycle after the response handshake.
  - No request/response overlap; minimum period per transaction is LATENCY+2 cycles.
- rsp_ready held high in IDLE/WAIT has no effect.
- A load following a store to the same word returns the stored data (the store commits before the load is accepted).
- Reset mid-transaction, in WAIT or RESP before the commit edge: abort, no memory write, outputs return to reset values. Memory is still cleared by the reset itself.
- req_be = 0 on a store: legal, no bytes change, normal acknowledge.

Test Plan:
- LATENCY=2, after reset: store addr 0x0, wdata 0x00000005, be 0xF -> rsp_valid rises 3 cycles after acceptance, rsp_err=0; then load addr 0x0 -> rsp_rdata=0x00000005.
- Store 0xAABBCCDD to addr 0x8 with be=0xF, then store 0x11223344 to addr 0x8 with be=0x5, then load addr 0x8 -> rsp_rdata=0xAA22CC44.
- Load addr 0x2 (misaligned) and load addr 0x400 (DEPTH=256, out of range) -> each gives rsp_err=1, rsp_rdata=0; memory unchanged (load addr 0x0 still returns its prior value).
- Hold rsp_ready=0 for 5 cycles in RESP while req_valid=1 with a new request -> rsp_valid/rsp_rdata stable, req_ready=0, second request not accepted; raise rsp_ready -> req_ready=1 the next cycle, second request accepted.
- LATENCY=0 build: back-to-back loads with rsp_ready=1 -> one transaction every 2 cycles, rsp_valid one cycle after each acceptance.
- Accept store 0x12345678 to addr 0x4, assert reset during WAIT -> outputs at reset values, req_ready=1 next cycle; load addr 0x4 -> rsp_rdata=0x00000000.
